wash_program_timer: RTL and testbench

- Program controller for the washing-machine front panel.
- Selects the wash program and computes per-phase and total remaining seconds from the water level.
- Runs the wash/rinse/dry sequence under the start/pause switch and raises a finish flag.
- Drives a keypress/finish beeper.
- Sits between the panel inputs (buttons, water-level block, 1 Hz tick) and the LED/7-segment display logic.

---
 rtl/wash_program_timer_pkg.sv | 95 +++++++++
 rtl/wash_program_timer_if.sv | 24 ++
 rtl/wash_program_timer_beeper.sv | 63 ++++++
 rtl/wash_program_timer.sv | 152 +++++++++++++++
 tb/tb_wash_program_timer.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wash_program_timer_pkg.sv
// Shared encodings and program/duration helpers for the washing-machine program timer.
package wash_program_timer_pkg;

    localparam logic [2:0] MODE_FULL       = 3'd1;
    localparam logic [2:0] MODE_WASH       = 3'd2;
    localparam logic [2:0] MODE_WASH_RINSE = 3'd3;
    localparam logic [2:0] MODE_RINSE_DRY  = 3'd4;
    localparam logic [2:0] MODE_DRY        = 3'd5;

    localparam logic [1:0] PH_NONE  = 2'd0;
    localparam logic [1:0] PH_WASH  = 2'd1;
    localparam logic [1:0] PH_RINSE = 2'd2;
    localparam logic [1:0] PH_DRY   = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [5:0] WASH_BASE  = 6'd4;
    localparam logic [5:0] RINSE_BASE = 6'd3;
    localparam logic [5:0] DRY_TIME   = 6'd3;
    localparam logic [3:0] L_MIN      = 4'd1;
    localparam logic [3:0] L_MAX      = 4'd5;

    function automatic logic [2:0] clamp_level(input logic [3:0] wl);
        logic [2:0] lv;
        if (wl < L_MIN) begin
            lv = L_MIN[2:0];
        end else if (wl > L_MAX) begin
            lv = L_MAX[2:0];
        end else begin
            lv = wl[2:0];
        end
        return lv;
    endfunction

    // PH_NONE has zero duration so sums over absent phases need no special case.
    function automatic logic [5:0] phase_dur(input logic [1:0] ph, input logic [2:0] lv);
        logic [5:0] d;
        case (ph)
            PH_WASH:  d = WASH_BASE + {3'b000, lv};
            PH_RINSE: d = RINSE_BASE + {3'b000, lv};
            PH_DRY:   d = DRY_TIME;
            default:  d = 6'd0;
        endcase
        return d;
    endfunction

    function automatic logic [1:0] first_phase(input logic [2:0] mode);
        logic [1:0] ph;
        case (mode)
            MODE_RINSE_DRY: ph = PH_RINSE;
            MODE_DRY:       ph = PH_DRY;
            default:        ph = PH_WASH;
        endcase
        return ph;
    endfunction

    function automatic logic [1:0] next_phase(input logic [2:0] mode, input logic [1:0] ph);
        logic [1:0] nx;
        case (ph)
            PH_WASH: begin
                if (mode == MODE_FULL || mode == MODE_WASH_RINSE) nx = PH_RINSE;
                else nx = PH_NONE;
            end
            PH_RINSE: begin
                if (mode == MODE_FULL || mode == MODE_RINSE_DRY) nx = PH_DRY;
                else nx = PH_NONE;
            end
            default: nx = PH_NONE;
        endcase
        return nx;
    endfunction

    function automatic logic [2:0] next_mode(input logic [2:0] mode);
        logic [2:0] nm;
        if (mode >= MODE_DRY) nm = MODE_FULL;
        else nm = mode + 3'd1;
        return nm;
    endfunction

    // No program has more than three phases, so at most two follow any phase.
    function automatic logic [5:0] remaining_after(input logic [2:0] mode, input logic [1:0] ph,
                                                   input logic [2:0] lv);
        logic [1:0] p1;
        logic [1:0] p2;
        p1 = next_phase(mode, ph);
        p2 = next_phase(mode, p1);
        return phase_dur(p1, lv) + phase_dur(p2, lv);
    endfunction

endpackage

// File: rtl/wash_program_timer_if.sv
// Front-panel bundle: buttons, water level and tick in; program/time/status display out.
interface wash_program_timer_if;
    logic       sec_tick;
    logic       start_pause;
    logic       module_select;
    logic       water_select;
    logic [3:0] water_level;
    logic [2:0] model_now;
    logic [1:0] phase;
    logic [5:0] time_now;
    logic [5:0] time_all;
    logic       finish;
    logic       buzzer;

    modport master (
        output sec_tick, start_pause, module_select, water_select, water_level,
        input  model_now, phase, time_now, time_all, finish, buzzer
    );

    modport slave (
        input  sec_tick, start_pause, module_select, water_select, water_level,
        output model_now, phase, time_now, time_all, finish, buzzer
    );
endinterface

// File: rtl/wash_program_timer_beeper.sv
// Panel beeper: button/switch/finish edge detection feeding a retriggerable on-time counter.
module wash_beeper #(
    parameter int unsigned BEEP_CYCLES = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic module_select,
    input  logic water_select,
    input  logic start_pause,
    input  logic finish,
    output logic module_rise,
    output logic buzzer
);
    localparam int unsigned CNT_W = $clog2(BEEP_CYCLES + 1);

    logic             module_q_r;
    logic             water_q_r;
    logic             start_q_r;
    logic             finish_q_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             buzzer_r;
    logic             event_s;

    assign module_rise = module_select & ~module_q_r;
    assign event_s     = module_rise
                       | (water_select & ~water_q_r)
                       | (start_pause ^ start_q_r)
                       | (finish & ~finish_q_r);
    assign buzzer      = buzzer_r;

    // Any event reloads the full on-time; otherwise count down to zero.
    always_comb begin
        cnt_next_s = cnt_r;
        if (event_s) begin
            cnt_next_s = CNT_W'(BEEP_CYCLES);
        end else if (cnt_r != {CNT_W{1'b0}}) begin
            cnt_next_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_next_s = {CNT_W{1'b0}};
        end
    end

    // Edge history tracks input levels during reset so held buttons do not beep on release.
    always_ff @(posedge clk) begin
        if (reset) begin
            module_q_r <= module_select;
            water_q_r  <= water_select;
            start_q_r  <= start_pause;
            finish_q_r <= finish;
            cnt_r      <= {CNT_W{1'b0}};
            buzzer_r   <= 1'b0;
        end else begin
            module_q_r <= module_select;
            water_q_r  <= water_select;
            start_q_r  <= start_pause;
            finish_q_r <= finish;
            cnt_r      <= cnt_next_s;
            buzzer_r   <= (cnt_next_s != {CNT_W{1'b0}});
        end
    end

endmodule

// File: rtl/wash_program_timer.sv
// Wash program controller: program select, phase sequencing on the 1 Hz tick, finish and beeper.
module wash_program_timer
    import wash_program_timer_pkg::*;
#(
    parameter int unsigned BEEP_CYCLES = 25_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 power_on,
    wash_program_timer_if.slave  pif
);
    logic       clear_s;
    state_t     state_r;
    state_t     state_next_s;
    logic [2:0] mode_r;
    logic [2:0] mode_next_s;
    logic [2:0] level_r;
    logic [2:0] level_next_s;
    logic [2:0] level_in_s;
    logic [1:0] phase_r;
    logic [1:0] phase_next_s;
    logic [1:0] first_ph_s;
    logic [1:0] next_ph_s;
    logic [5:0] time_now_r;
    logic [5:0] time_now_next_s;
    logic [5:0] time_all_r;
    logic [5:0] time_all_next_s;
    logic [5:0] idle_now_s;
    logic [5:0] idle_all_s;
    logic       finish_r;
    logic       finish_next_s;
    logic       module_rise_s;
    logic       buzzer_s;

    assign clear_s    = reset | ~power_on;
    assign level_in_s = clamp_level(pif.water_level);
    assign first_ph_s = first_phase(mode_r);
    assign idle_now_s = phase_dur(first_ph_s, level_in_s);
    assign idle_all_s = idle_now_s + remaining_after(mode_r, first_ph_s, level_in_s);
    assign next_ph_s  = next_phase(mode_r, phase_r);

    wash_beeper #(
        .BEEP_CYCLES (BEEP_CYCLES)
    ) u_beeper (
        .clk           (clk),
        .reset         (clear_s),
        .module_select (pif.module_select),
        .water_select  (pif.water_select),
        .start_pause   (pif.start_pause),
        .finish        (finish_r),
        .module_rise   (module_rise_s),
        .buzzer        (buzzer_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (clear_s) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state and datapath; a mode press in IDLE wins over start so RUN uses the new mode.
    always_comb begin
        state_next_s    = state_r;
        mode_next_s     = mode_r;
        level_next_s    = level_r;
        phase_next_s    = phase_r;
        time_now_next_s = time_now_r;
        time_all_next_s = time_all_r;
        finish_next_s   = finish_r;
        case (state_r)
            IDLE: begin
                phase_next_s    = PH_NONE;
                time_now_next_s = idle_now_s;
                time_all_next_s = idle_all_s;
                finish_next_s   = 1'b0;
                if (module_rise_s) begin
                    mode_next_s = next_mode(mode_r);
                end else if (pif.start_pause) begin
                    state_next_s = RUN;
                    level_next_s = level_in_s;
                    phase_next_s = first_ph_s;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (!pif.start_pause) begin
                    state_next_s = PAUSE;
                end else if (pif.sec_tick) begin
                    time_all_next_s = time_all_r - 6'd1;
                    if (time_now_r > 6'd1) begin
                        time_now_next_s = time_now_r - 6'd1;
                    end else if (next_ph_s != PH_NONE) begin
                        phase_next_s    = next_ph_s;
                        time_now_next_s = phase_dur(next_ph_s, level_r);
                    end else begin
                        time_now_next_s = 6'd0;
                        time_all_next_s = 6'd0;
                        phase_next_s    = PH_NONE;
                        finish_next_s   = 1'b1;
                        state_next_s    = DONE;
                    end
                end else begin
                    state_next_s = RUN;
                end
            end
            PAUSE: begin
                if (pif.start_pause) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = PAUSE;
                end
            end
            DONE: begin
                state_next_s = DONE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Datapath registers; times are cleared here and reloaded by IDLE on the following cycle.
    always_ff @(posedge clk) begin
        if (clear_s) begin
            mode_r     <= MODE_FULL;
            level_r    <= L_MIN[2:0];
            phase_r    <= PH_NONE;
            time_now_r <= 6'd0;
            time_all_r <= 6'd0;
            finish_r   <= 1'b0;
        end else begin
            mode_r     <= mode_next_s;
            level_r    <= level_next_s;
            phase_r    <= phase_next_s;
            time_now_r <= time_now_next_s;
            time_all_r <= time_all_next_s;
            finish_r   <= finish_next_s;
        end
    end

    assign pif.model_now = mode_r;
    assign pif.phase     = phase_r;
    assign pif.time_now  = time_now_r;
    assign pif.time_all  = time_all_r;
    assign pif.finish    = finish_r;
    assign pif.buzzer    = buzzer_s;

endmodule

// File: tb/tb_wash_program_timer.sv
// Directed and randomized checks of wash_program_timer against an elapsed-seconds program model.
module tb_wash_program_timer;
    logic clk = 1'b0;
    logic reset;
    logic power_on;
    int   checks   = 0;
    int   failures = 0;

    wash_program_timer_if pif ();

    wash_program_timer #(.BEEP_CYCLES(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .power_on (power_on),
        .pif      (pif)
    );

    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Program table: phase list per mode, 1 = wash, 2 = rinse, 3 = dry, 0 = absent.
    function automatic int prog_phase(input int m, input int i);
        case (m)
            1: return i + 1;
            2: return (i == 0) ? 1 : 0;
            3: return (i < 2) ? i + 1 : 0;
            4: return (i < 2) ? i + 2 : 0;
            5: return (i == 0) ? 3 : 0;
            default: return 0;
        endcase
    endfunction

    function automatic int dur_of(input int ph, input int lv);
        case (ph)
            1: return 4 + lv;
            2: return 3 + lv;
            3: return 3;
            default: return 0;
        endcase
    endfunction

    function automatic int clamp_l(input int wl);
        return (wl < 1) ? 1 : ((wl > 5) ? 5 : wl);
    endfunction

    function automatic int total_of(input int m, input int lv);
        int t = 0;
        for (int i = 0; i < 3; i++) t += dur_of(prog_phase(m, i), lv);
        return t;
    endfunction

    // Expected display after e counted seconds of program m at level lv.
    function automatic void exp_state(input int m, input int lv, input int e,
                                      output int eph, output int etn, output int eta);
        int rem;
        int tot;
        int ph;
        int d;
        tot = total_of(m, lv);
        eph = 0; etn = 0; eta = 0; rem = e;
        if (e < tot) begin
            eta = tot - e;
            for (int i = 0; i < 3; i++) begin
                ph = prog_phase(m, i);
                d  = dur_of(ph, lv);
                if (ph != 0 && eph == 0) begin
                    if (rem < d) begin
                        eph = ph;
                        etn = d - rem;
                    end else begin
                        rem -= d;
                    end
                end
            end
        end
    endfunction

    task automatic check_run(input string tag, input int m, input int lv, input int e);
        int eph, etn, eta;
        exp_state(m, lv, e, eph, etn, eta);
        chk({tag, "_phase"}, pif.phase, eph);
        chk({tag, "_tnow"}, pif.time_now, etn);
        chk({tag, "_tall"}, pif.time_all, eta);
        chk({tag, "_finish"}, pif.finish, (e >= total_of(m, lv)) ? 1 : 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pif.sec_tick = 1'b0; pif.start_pause = 1'b0;
        pif.module_select = 1'b0; pif.water_select = 1'b0;
        step(2);
        reset = 1'b0;
        step(1);
    endtask

    task automatic press_module();
        pif.module_select = 1'b1;
        step(1);
        pif.module_select = 1'b0;
        step(1);
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            pif.sec_tick = 1'b1;
            step(1);
        end
        pif.sec_tick = 1'b0;
    endtask

    initial begin
        int cnt, m, wl, lv, e, cyc, running, sp, tk, eph, etn, eta;
        power_on = 1'b1; reset = 1'b1;
        pif.sec_tick = 1'b0; pif.start_pause = 1'b0;
        pif.module_select = 1'b0; pif.water_select = 1'b0; pif.water_level = 4'd3;

        // Reset state, program 1 at level 3.
        do_reset();
        chk("reset_model", pif.model_now, 1);
        chk("reset_phase", pif.phase, 0);
        chk("reset_finish", pif.finish, 0);
        chk("reset_buzzer", pif.buzzer, 0);
        chk("idle_tnow_m1", pif.time_now, 7);
        chk("idle_tall_m1", pif.time_all, 16);

        // Program selection and wrap.
        repeat (3) press_module();
        chk("sel_model4", pif.model_now, 4);
        chk("idle_tnow_m4", pif.time_now, 6);
        chk("idle_tall_m4", pif.time_all, 9);
        repeat (2) press_module();
        chk("sel_wrap1", pif.model_now, 1);
        repeat (4) press_module();
        chk("sel_model5", pif.model_now, 5);

        // Program 3 at clamped level 5 through to finish.
        pif.water_level = 4'd9;
        do_reset();
        repeat (2) press_module();
        chk("p3_idle_tnow", pif.time_now, 9);
        chk("p3_idle_tall", pif.time_all, 17);
        pif.start_pause = 1'b1;
        step(1);
        check_run("p3_start", 3, 5, 0);
        tick_n(9);
        check_run("p3_rinse", 3, 5, 9);
        tick_n(8);
        check_run("p3_done", 3, 5, 17);
        cnt = 0;
        repeat (10) begin step(1); cnt += int'(pif.buzzer); end
        chk("finish_beep_len", cnt, 4);
        pif.module_select = 1'b1;
        step(1);
        chk("done_press_beep", pif.buzzer, 1);
        pif.module_select = 1'b0;
        step(1);
        chk("done_model_held", pif.model_now, 3);
        chk("done_finish_held", pif.finish, 1);

        // Program 1 at level 0 (clamped 1): pause, resume, latched level.
        pif.water_level = 4'd0;
        do_reset();
        pif.start_pause = 1'b1;
        step(1);
        tick_n(2);
        check_run("p1_run2", 1, 1, 2);
        pif.start_pause = 1'b0;
        step(1);
        tick_n(5);
        check_run("p1_paused", 1, 1, 2);
        pif.water_level = 4'd5;
        pif.start_pause = 1'b1;
        step(1);
        tick_n(1);
        check_run("p1_resume", 1, 1, 3);
        tick_n(2);
        check_run("p1_rinse_latched", 1, 1, 5);
        pif.start_pause = 1'b0; pif.sec_tick = 1'b1;
        step(1);
        pif.sec_tick = 1'b0;
        check_run("p1_tick_on_pause", 1, 1, 5);
        pif.start_pause = 1'b1;
        step(1);

        // Power switch off mid-run.
        power_on = 1'b0;
        step(1);
        chk("poff_model", pif.model_now, 1);
        chk("poff_phase", pif.phase, 0);
        chk("poff_finish", pif.finish, 0);
        chk("poff_buzzer", pif.buzzer, 0);
        pif.start_pause = 1'b0;
        step(1);
        power_on = 1'b1;
        step(1);
        chk("pon_idle_tnow", pif.time_now, 9);
        chk("pon_idle_tall", pif.time_all, 20);

        // Mode press and start together: mode advances, RUN follows with the new mode.
        pif.module_select = 1'b1; pif.start_pause = 1'b1;
        step(1);
        chk("simul_model", pif.model_now, 2);
        chk("simul_still_idle", pif.phase, 0);
        pif.module_select = 1'b0;
        step(1);
        check_run("simul_run", 2, 5, 0);

        // Beeper length and retrigger.
        do_reset();
        step(6);
        chk("beep_quiet", pif.buzzer, 0);
        cnt = 0;
        pif.module_select = 1'b1;
        step(1); cnt += int'(pif.buzzer);
        pif.module_select = 1'b0;
        repeat (9) begin step(1); cnt += int'(pif.buzzer); end
        chk("beep_single_len", cnt, 4);
        cnt = 0;
        pif.module_select = 1'b1;
        step(1); cnt += int'(pif.buzzer);
        pif.module_select = 1'b0;
        step(1); cnt += int'(pif.buzzer);
        pif.water_select = 1'b1;
        step(1); cnt += int'(pif.buzzer);
        pif.water_select = 1'b0;
        repeat (8) begin step(1); cnt += int'(pif.buzzer); end
        chk("beep_retrigger_len", cnt, 6);

        // Randomized programs, levels, ticks, pauses and ignored level changes.
        for (int r = 0; r < 12; r++) begin
            m  = int'($urandom_range(1, 5));
            wl = int'($urandom_range(0, 15));
            lv = clamp_l(wl);
            pif.water_level = 4'(wl);
            do_reset();
            repeat (m - 1) press_module();
            exp_state(m, lv, 0, eph, etn, eta);
            chk("rand_idle_model", pif.model_now, m);
            chk("rand_idle_tnow", pif.time_now, etn);
            chk("rand_idle_tall", pif.time_all, eta);
            pif.start_pause = 1'b1;
            step(1);
            running = 1; e = 0; cyc = 0;
            while (e < total_of(m, lv) && cyc < 500) begin
                sp = running ? int'($urandom_range(0, 7) != 0) : int'($urandom_range(0, 2) != 0);
                tk = int'($urandom_range(0, 1));
                if ($urandom_range(0, 5) == 0) pif.water_level = 4'($urandom_range(0, 15));
                pif.start_pause = sp[0];
                pif.sec_tick = tk[0];
                step(1);
                pif.sec_tick = 1'b0;
                if (running != 0 && sp != 0 && tk != 0) e++;
                running = sp;
                check_run("rand", m, lv, e);
                cyc++;
            end
            if (e < total_of(m, lv)) chk("rand_timeout", e, total_of(m, lv));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
